// File: rtl/booth_seq_ctrl_if.sv
// Operand/product handshake bundle for the sequential Booth multiplier.
// The producer/consumer side uses master; the multiplier uses slave.
interface booth_seq_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 abort;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, a, b, abort, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, abort, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock,
// WIDTH steps per product, valid/ready on both the operand and product sides.
module booth_seq_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    booth_seq_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q;
    logic [WIDTH:0]       m_q;
    logic [WIDTH:0]       acc_q;
    logic [WIDTH-1:0]     mlr_q;
    logic                 q1_q;
    logic [CntW-1:0]      cnt_q;
    logic [2*WIDTH-1:0]   p_q;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       acc_shift;
    logic [WIDTH-1:0]     mlr_shift;

    // Booth recode on {Q[0], q_1}, then arithmetic shift of {A, Q, q_1}.
    always_comb begin
        sum = acc_q;
        case ({mlr_q[0], q1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
        acc_shift = {sum[WIDTH], sum[WIDTH:1]};
        mlr_shift = {sum[0], mlr_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            mlr_q   <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        m_q     <= {bus.a[WIDTH-1], bus.a};
                        acc_q   <= '0;
                        mlr_q   <= bus.b;
                        q1_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    // abort wins over the final step, so p keeps its old value
                    if (bus.abort) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_shift;
                        mlr_q <= mlr_shift;
                        q1_q  <= mlr_q[0];
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == CntW'(WIDTH - 1)) begin
                            p_q     <= {acc_shift[WIDTH-1:0], mlr_shift};
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (bus.abort || bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.p         = p_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (WIDTH=4) against a plain signed-multiply model.
module tb_booth_seq_ctrl;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [2*W-1:0] expq[$];

    always #5 clk = ~clk;

    booth_seq_ctrl_if #(.WIDTH(W)) bus ();

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        return (2*W)'(sx * sy);
    endfunction

    // Offers one operand pair, then reports edges from acceptance to out_valid and p.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output logic [2*W-1:0] pv);
        int guard = 0;
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        pv = bus.p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100)
            begin n_fail++; $display("FAIL reset_flags: got %b expected 100",
                                     {bus.in_ready, bus.out_valid, bus.busy}); end
        n_tests++;
        if (bus.p !== '0) begin n_fail++; $display("FAIL reset_p: got %h expected 00", bus.p); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.in_ready, bus.busy} !== 2'b10)
            begin n_fail++; $display("FAIL idle_after_reset: got %b expected 10",
                                     {bus.in_ready, bus.busy}); end
    endtask

    task automatic test_basic();
        int lat;
        logic [2*W-1:0] pv;
        bus.out_ready = 1'b1;
        do_op(4'd3, 4'd5, lat, pv);
        n_tests++;
        if (lat != int'(W)) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, W); end
        n_tests++;
        if (pv !== 8'h0F) begin n_fail++; $display("FAIL basic_p: got %h expected 0f", pv); end
        @(negedge clk);
        n_tests++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            begin n_fail++; $display("FAIL basic_one_cycle: out_valid,in_ready got %b expected 01",
                                     {bus.out_valid, bus.in_ready}); end
    endtask

    task automatic test_corners();
        logic [W-1:0]   ca [4];
        logic [W-1:0]   cb [4];
        logic [2*W-1:0] cp [4];
        int lat;
        logic [2*W-1:0] pv;
        ca = '{4'h8, 4'hD, 4'h7, 4'h0};
        cb = '{4'h8, 4'h7, 4'h8, 4'hF};
        cp = '{8'h40, 8'hEB, 8'hC8, 8'h00};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(ca[i], cb[i], lat, pv);
            n_tests++;
            if (pv !== cp[i]) begin n_fail++;
                $display("FAIL corner_p[%0d]: a=%h b=%h got %h expected %h", i, ca[i], cb[i], pv, cp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int nres = 0;
        int cyc = 0;
        int last_acc = -1;
        logic [7:0] pair;
        logic [2*W-1:0] e;
        expq.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        while (nres < 256 && cyc < 4000) begin
            if (bus.out_valid === 1'b1) begin
                n_tests++;
                if (expq.size() == 0) begin n_fail++;
                    $display("FAIL sweep_extra: got p=%h expected no pending result", bus.p);
                end else begin
                    e = expq.pop_front();
                    if (bus.p !== e) begin n_fail++;
                        $display("FAIL sweep_p[%0d]: got %h expected %h", nres, bus.p, e); end
                end
                nres++;
            end
            if (idx < 256) begin
                pair = 8'(idx);
                bus.a = pair[7:4];
                bus.b = pair[3:0];
                bus.in_valid = 1'b1;
                if (bus.in_ready === 1'b1) begin
                    expq.push_back(ref_mul(pair[7:4], pair[3:0]));
                    if (last_acc >= 0) begin
                        n_tests++;
                        if (cyc - last_acc != int'(W) + 2) begin n_fail++;
                            $display("FAIL sweep_spacing[%0d]: got %0d expected %0d",
                                     idx, cyc - last_acc, int'(W) + 2); end
                    end
                    last_acc = cyc;
                    idx++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (nres != 256) begin n_fail++; $display("FAIL sweep_count: got %0d expected 256", nres); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2*W-1:0] pv;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        av = W'($urandom);
        bv = W'($urandom);
        bus.out_ready = 1'b0;
        do_op(av, bv, lat, pv);
        n_tests++;
        if (pv !== ref_mul(av, bv)) begin n_fail++;
            $display("FAIL bp_p: got %h expected %h", pv, ref_mul(av, bv)); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b101 || bus.p !== pv) begin n_fail++;
                $display("FAIL bp_hold[%0d]: flags %b p %h expected 101 p %h",
                         i, {bus.out_valid, bus.in_ready, bus.busy}, bus.p, pv); end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_fail++;
            $display("FAIL bp_release: got %b expected 01", {bus.out_valid, bus.in_ready}); end
    endtask

    task automatic test_random();
        int lat;
        int d;
        logic [2*W-1:0] pv;
        logic [2*W-1:0] e;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        for (int n = 0; n < 24; n++) begin
            av = W'($urandom);
            bv = W'($urandom);
            e = ref_mul(av, bv);
            d = int'($urandom_range(0, 3));
            bus.out_ready = 1'b0;
            do_op(av, bv, lat, pv);
            n_tests++;
            if (lat != int'(W) || pv !== e) begin n_fail++;
                $display("FAIL rand_op[%0d]: a=%h b=%h lat %0d p %h expected lat %0d p %h",
                         n, av, bv, lat, pv, W, e); end
            repeat (d) @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.p !== e) begin n_fail++;
                $display("FAIL rand_hold[%0d]: out_valid %b p %h expected 1 p %h",
                         n, bus.out_valid, bus.p, e); end
            bus.out_ready = 1'b1;
            @(negedge clk);
            n_tests++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_fail++;
                $display("FAIL rand_release[%0d]: got %b expected 01", n, {bus.out_valid, bus.in_ready}); end
        end
    endtask

    task automatic test_abort();
        int lat;
        logic [2*W-1:0] pv;
        bit seen;
        bus.out_ready = 1'b1;
        do_op(4'd2, 4'd3, lat, pv);
        @(negedge clk);
        // abort in IDLE must not block acceptance
        bus.a = 4'd5;
        bus.b = 4'd3;
        bus.in_valid = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.abort = 1'b0;
        n_tests++;
        if ({bus.busy, bus.in_ready} !== 2'b10) begin n_fail++;
            $display("FAIL abort_idle: busy,in_ready got %b expected 10", {bus.busy, bus.in_ready}); end
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_tests++;
        if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100 || bus.p !== 8'h06) begin n_fail++;
            $display("FAIL abort_run: flags %b p %h expected 100 p 06",
                     {bus.in_ready, bus.busy, bus.out_valid}, bus.p); end
        seen = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL abort_no_output: got out_valid 1 expected 0"); end
        // abort on the final RUN cycle beats the RUN->DONE transition
        bus.a = 4'd6;
        bus.b = 4'd7;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (W - 1) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10 || bus.p !== 8'h06) begin n_fail++;
            $display("FAIL abort_last_step: flags %b p %h expected 10 p 06",
                     {bus.in_ready, bus.out_valid}, bus.p); end
        do_op(4'hD, 4'd7, lat, pv);
        n_tests++;
        if (lat != int'(W) || pv !== ref_mul(4'hD, 4'd7)) begin n_fail++;
            $display("FAIL abort_recover: lat %0d p %h expected lat %0d p %h",
                     lat, pv, W, ref_mul(4'hD, 4'd7)); end
    endtask

    task automatic test_async_reset();
        int lat;
        logic [2*W-1:0] pv;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.a = 4'd3;
        bus.b = 4'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 || bus.p !== '0) begin n_fail++;
            $display("FAIL rst_mid_run: flags %b p %h expected 100 p 00",
                     {bus.in_ready, bus.out_valid, bus.busy}, bus.p); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'd5, 4'd5, lat, pv);
        n_tests++;
        if (pv !== 8'h19) begin n_fail++; $display("FAIL rst_pre_done_p: got %h expected 19", pv); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 || bus.p !== '0) begin n_fail++;
            $display("FAIL rst_in_done: flags %b p %h expected 100 p 00",
                     {bus.in_ready, bus.out_valid, bus.busy}, bus.p); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        do_op(4'hF, 4'hF, lat, pv);
        n_tests++;
        if (lat != int'(W) || pv !== 8'h01) begin n_fail++;
            $display("FAIL rst_first_op: lat %0d p %h expected lat %0d p 01", lat, pv, W); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
